// File: rtl/snake_turn_ctrl_pkg.sv
// Shared types and constants for the snake turn controller and its dice counter.
// Board geometry, dice range and the turn FSM encoding live here.
package snake_turn_ctrl_pkg;

    localparam int POS_W  = 7;
    localparam int DICE_W = 3;

    localparam logic [POS_W-1:0]  BOARD_MAX = 7'd100;
    localparam logic [DICE_W-1:0] DICE_MAX  = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        UPDATE  = 3'd3,
        WIN     = 3'd4
    } state_t;

    // Position 0 is off-board, so only 1..BOARD_MAX is a legal resolved square.
    function automatic logic pos_in_range(input logic [POS_W-1:0] p);
        return (p != '0) && (p <= BOARD_MAX);
    endfunction

    function automatic logic [1:0] next_player(input logic [1:0] cur, input int num_players);
        return (cur == 2'(num_players - 1)) ? 2'd0 : cur + 2'd1;
    endfunction

endpackage

// File: rtl/snake_turn_ctrl_if.sv
// Move-stage link: the controller presents a move, the combinational stage
// answers with the resolved square in the same cycle.
interface snake_turn_ctrl_if;
    import snake_turn_ctrl_pkg::*;

    // mv_valid qualifies mv_position/mv_dice; there is no ready, the stage is
    // combinational and mv_new_position is only meaningful while mv_valid=1.
    logic [POS_W-1:0]  mv_position;
    logic [DICE_W-1:0] mv_dice;
    logic              mv_valid;
    logic [POS_W-1:0]  mv_new_position;

    modport master (
        output mv_position,
        output mv_dice,
        output mv_valid,
        input  mv_new_position
    );

    modport slave (
        input  mv_position,
        input  mv_dice,
        input  mv_valid,
        output mv_new_position
    );

endinterface

// File: rtl/snake_dice_counter.sv
// Free-running dice: steps 1..DICE_MAX every clock, wrapping back to 1.
module snake_dice_counter
    import snake_turn_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [DICE_W-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 3'd1;
        end else if (value == DICE_MAX) begin
            value <= 3'd1;
        end else begin
            value <= value + 3'd1;
        end
    end

endmodule

// File: rtl/snake_turn_ctrl.sv
// Turn controller: takes a roll, presents the move to the move stage, captures
// the resolved square and advances the player rotation until someone wins.
module snake_turn_ctrl
    import snake_turn_ctrl_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              roll_req,
    input  logic              new_game,
    input  logic              dice_force_en,
    input  logic [DICE_W-1:0] dice_force_val,
    snake_turn_ctrl_if.master mv,
    output logic [1:0]        cur_player,
    output logic [DICE_W-1:0] last_dice,
    output logic              busy,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic              err,
    output state_t            state
);

    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

    logic [DICE_W-1:0] dice_value;
    logic [DICE_W-1:0] roll_val;
    logic [1:0]        settle_cnt;
    logic [POS_W-1:0]  pos [4];

    snake_dice_counter u_dice (
        .clk   (clk),
        .rst_n (rst_n),
        .value (dice_value)
    );

    assign roll_val = dice_force_en ? dice_force_val : dice_value;

    // Single FSM; every output is a register so nothing glitches toward the move stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            for (int i = 0; i < 4; i++) pos[i] <= '0;
            mv.mv_valid    <= 1'b0;
            mv.mv_position <= '0;
            mv.mv_dice     <= '0;
            cur_player     <= '0;
            last_dice      <= '0;
            busy           <= 1'b0;
            game_over      <= 1'b0;
            winner         <= '0;
            err            <= 1'b0;
        end else if (new_game) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            for (int i = 0; i < 4; i++) pos[i] <= '0;
            mv.mv_valid    <= 1'b0;
            mv.mv_position <= '0;
            mv.mv_dice     <= '0;
            cur_player     <= '0;
            last_dice      <= '0;
            busy           <= 1'b0;
            game_over      <= 1'b0;
            winner         <= '0;
            err            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (roll_req) begin
                        last_dice      <= roll_val;
                        mv.mv_valid    <= 1'b1;
                        mv.mv_position <= pos[cur_player];
                        mv.mv_dice     <= roll_val;
                        busy           <= 1'b1;
                        settle_cnt     <= '0;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end
                CAPTURE: begin
                    // An out-of-board answer leaves the player where they were.
                    if (pos_in_range(mv.mv_new_position)) begin
                        pos[cur_player] <= mv.mv_new_position;
                    end else begin
                        err <= 1'b1;
                    end
                    mv.mv_valid    <= 1'b0;
                    mv.mv_position <= '0;
                    mv.mv_dice     <= '0;
                    state          <= UPDATE;
                end
                UPDATE: begin
                    busy <= 1'b0;
                    if (pos[cur_player] == BOARD_MAX) begin
                        winner    <= cur_player;
                        game_over <= 1'b1;
                        state     <= WIN;
                    end else begin
                        if (last_dice != DICE_MAX) begin
                            cur_player <= next_player(cur_player, NUM_PLAYERS);
                        end
                        state <= IDLE;
                    end
                end
                WIN: begin
                    state <= WIN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_turn_ctrl.sv
// Bench for snake_turn_ctrl: randomized turns against a game-level model,
// with expected moves and turn results queued for an independent monitor.
module tb_snake_turn_ctrl;
    import snake_turn_ctrl_pkg::*;

    localparam int NP = 3;
    localparam int S  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       roll_req = 1'b0;
    logic       new_game = 1'b0;
    logic       dice_force_en = 1'b0;
    logic [2:0] dice_force_val = 3'd1;
    logic [1:0] cur_player;
    logic [2:0] last_dice;
    logic       busy;
    logic       game_over;
    logic [1:0] winner;
    logic       err;
    state_t     dut_state;
    logic [6:0] resp_r = 7'd0;

    snake_turn_ctrl_if mvif ();
    assign mvif.mv_new_position = mvif.mv_valid ? resp_r : 7'd0;

    snake_turn_ctrl #(.NUM_PLAYERS(NP), .SETTLE_CYCLES(S)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .roll_req       (roll_req),
        .new_game       (new_game),
        .dice_force_en  (dice_force_en),
        .dice_force_val (dice_force_val),
        .mv             (mvif.master),
        .cur_player     (cur_player),
        .last_dice      (last_dice),
        .busy           (busy),
        .game_over      (game_over),
        .winner         (winner),
        .err            (err),
        .state          (dut_state)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset release; the free dice reads 1 + edges mod 6.
    int edge_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    int check_cnt = 0;
    int err_cnt = 0;
    int exp_moves = 0;
    int moves_seen = 0;
    logic [9:0] exp_mv_q[$];
    logic [8:0] exp_st_q[$];

    int m_pos[4];
    int m_cur, m_err, m_over, m_winner;

    task automatic check(input string name, input int act, input int exp);
        check_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_pos[i] = 0;
        m_cur = 0; m_err = 0; m_over = 0; m_winner = 0;
    endtask

    // Monitor: pops expectations when a move appears and when a turn completes.
    logic       prev_valid = 1'b0;
    logic       prev_busy = 1'b0;
    int         vcnt = 0;
    logic [9:0] cur_mv = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0; prev_busy = 1'b0; vcnt = 0;
        end else begin
            if (mvif.mv_valid) begin
                if (!prev_valid) begin
                    moves_seen++;
                    if (exp_mv_q.size() == 0) begin
                        check("unexpected_move", 1, 0);
                        cur_mv = {mvif.mv_position, mvif.mv_dice};
                    end else begin
                        cur_mv = exp_mv_q.pop_front();
                    end
                end
                check("mv_position", 32'(mvif.mv_position), 32'(cur_mv[9:3]));
                check("mv_dice", 32'(mvif.mv_dice), 32'(cur_mv[2:0]));
                vcnt++;
            end else begin
                if (prev_valid) check("mv_valid_width", vcnt, S + 1);
                vcnt = 0;
                check("mv_idle_zero", 32'({mvif.mv_position, mvif.mv_dice}), 0);
            end
            if (prev_busy && !busy) begin
                logic [8:0] s;
                if (exp_st_q.size() == 0) begin
                    check("unexpected_turn_end", 1, 0);
                end else begin
                    s = exp_st_q.pop_front();
                    check("cur_player", 32'(cur_player), 32'(s[8:7]));
                    check("last_dice", 32'(last_dice), 32'(s[6:4]));
                    check("err", 32'(err), 32'(s[3]));
                    check("game_over", 32'(game_over), 32'(s[2]));
                    check("winner", 32'(winner), 32'(s[1:0]));
                end
            end
            prev_valid = mvif.mv_valid;
            prev_busy  = busy;
        end
    end

    // Called just after a rising edge with the DUT idle (or won).
    task automatic do_turn(input bit fen, input int fval, input int resp, input bit noisy);
        int n;
        int dice;
        bit was_over;
        n = 0;
        while (busy && n < 50) begin @(posedge clk); #1; n++; end
        check("idle_before_roll", 32'(busy), 0);
        dice = fen ? fval : 1 + (edge_cnt % 6);
        was_over = (m_over != 0);
        if (!was_over) begin
            exp_mv_q.push_back({7'(m_pos[m_cur]), 3'(dice)});
            exp_moves++;
            if (resp >= 1 && resp <= 100) m_pos[m_cur] = resp;
            else m_err = 1;
            if (m_pos[m_cur] == 100) begin
                m_over = 1; m_winner = m_cur;
            end else if (dice != 6) begin
                m_cur = (m_cur + 1) % NP;
            end
            exp_st_q.push_back({2'(m_cur), 3'(dice), 1'(m_err), 1'(m_over), 2'(m_winner)});
        end
        resp_r = 7'(resp);
        roll_req = 1'b1;
        dice_force_en = fen;
        dice_force_val = 3'(fval);
        @(posedge clk); #1;
        for (int j = 0; j < S + 2; j++) begin
            roll_req = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            dice_force_en = 1'($urandom_range(0, 1));
            dice_force_val = 3'($urandom_range(1, 6));
            @(posedge clk); #1;
        end
        roll_req = 1'b0;
        dice_force_en = 1'b0;
        if (was_over) begin
            check("win_roll_busy", 32'(busy), 0);
            check("win_roll_mv_valid", 32'(mvif.mv_valid), 0);
            check("win_hold_game_over", 32'(game_over), 1);
            check("win_hold_winner", 32'(winner), m_winner);
        end
    endtask

    task automatic do_new_game(input bit with_roll);
        new_game = 1'b1;
        roll_req = with_roll;
        @(posedge clk); #1;
        new_game = 1'b0;
        roll_req = 1'b0;
        model_clear();
        check("ng_cur_player", 32'(cur_player), 0);
        check("ng_last_dice", 32'(last_dice), 0);
        check("ng_err", 32'(err), 0);
        check("ng_game_over", 32'(game_over), 0);
        check("ng_winner", 32'(winner), 0);
        check("ng_state", 32'(dut_state), 32'(IDLE));
        repeat (S + 2) @(posedge clk);
        #1;
        check("ng_no_move", 32'({busy, mvif.mv_valid}), 0);
    endtask

    task automatic reset_mid_issue();
        exp_mv_q.push_back({7'(m_pos[m_cur]), 3'd2});
        exp_moves++;
        resp_r = 7'd50;
        roll_req = 1'b1; dice_force_en = 1'b1; dice_force_val = 3'd2;
        @(posedge clk); #1;
        roll_req = 1'b0; dice_force_en = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_valid", 32'(mvif.mv_valid), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mv_valid", 32'(mvif.mv_valid), 0);
        check("rst_mv_bus", 32'({mvif.mv_position, mvif.mv_dice}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_outputs", 32'({cur_player, last_dice, game_over, winner, err}), 0);
        check("rst_state", 32'(dut_state), 32'(IDLE));
        exp_st_q.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int resp, p, dice, fen, sel;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({cur_player, last_dice, busy, game_over, winner, err}), 0);
        check("reset_mv", 32'({mvif.mv_valid, mvif.mv_position, mvif.mv_dice}), 0);
        rst_n = 1'b1;
        check("reset_state", 32'(dut_state), 32'(IDLE));

        // First move, bonus turn on a six, then a re-roll from the new square.
        do_turn(1, 4, 14, 0);
        do_turn(1, 5, 20, 1);
        do_turn(1, 1, 1, 1);
        do_turn(1, 2, 16, 1);
        do_turn(1, 6, 26, 1);
        do_turn(1, 3, 29, 1);
        // Off-board answer sets a sticky err; clear it with new_game plus roll.
        do_turn(1, 2, 105, 1);
        do_turn(1, 1, 17, 0);
        do_new_game(1);
        // Player 0 reaches exactly 100.
        do_turn(1, 1, 97, 1);
        do_turn(1, 1, 1, 1);
        do_turn(1, 1, 1, 1);
        do_turn(1, 3, 100, 1);
        do_turn(1, 2, 50, 1);
        do_new_game(0);

        for (int t = 0; t < 70; t++) begin
            fen = $urandom_range(0, 1);
            dice = fen ? $urandom_range(1, 6) : 1 + ((edge_cnt + 1) % 6);
            p = m_pos[m_cur];
            sel = $urandom_range(0, 9);
            if (sel == 0)      resp = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(101, 127);
            else if (sel == 1) resp = $urandom_range(1, 100);
            else if (sel == 2) resp = 100;
            else               resp = (p + dice > 100) ? p : p + dice;
            if (resp == 0 && p == 0) resp = dice;
            do_turn(fen[0], $urandom_range(1, 6), resp, 1'($urandom_range(0, 1)));
            if (m_over != 0) begin
                if ($urandom_range(0, 1) != 0) do_turn(0, 1, 40, 1);
                do_new_game(1'($urandom_range(0, 1)));
            end
        end

        reset_mid_issue();
        do_turn(0, 1, 7, 0);
        do_turn(0, 1, 9, 1);

        n = 0;
        while ((exp_mv_q.size() != 0 || exp_st_q.size() != 0 || busy) && n < 200) begin
            @(posedge clk); n++;
        end
        repeat (2) @(posedge clk);
        check("drain_mv_q", exp_mv_q.size(), 0);
        check("drain_st_q", exp_st_q.size(), 0);
        check("move_count", moves_seen, exp_moves);
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
